// File: rtl/trace_player_pkg.sv
// Shared types and constants for the branch trace player and its trace RAM.
package trace_player_pkg;

  typedef enum logic [1:0] {StIdle, StPrime, StRun, StDone} state_e;

  // Entry layout: {pc, outcome}, outcome in bit 0.
  localparam int unsigned DefaultPcW = 8;
  localparam int unsigned ENTRY_W    = DefaultPcW + 1;
  localparam int unsigned OutcomeBit = 0;
  localparam int unsigned PcLsb      = 1;

  function automatic int unsigned entry_w(input int unsigned pc_w);
    return pc_w + 1;
  endfunction

endpackage

// File: rtl/trace_mem.sv
// Single-write, synchronous-read RAM holding the branch trace; no reset so it maps to block RAM.
module trace_mem #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned ENTRY_W = 9
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [ENTRY_W-1:0] rd_data
);

  logic [ENTRY_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/branch_trace_player.sv
// Replays a stored branch trace into a predictor at one branch per cycle and scores its accuracy.
module branch_trace_player
  import trace_player_pkg::*;
#(
  parameter int unsigned PC_W   = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [PC_W-1:0]   load_pc,
  input  logic              load_outcome,
  input  logic [ADDR_W:0]   trace_len,
  input  logic              start,
  output logic              predict_enable,
  output logic [PC_W-1:0]   branch_pc,
  output logic              actual_outcome,
  input  logic              prediction,
  output logic              busy,
  output logic              done,
  output logic              mispredict,
  output logic [CNT_W-1:0]  num_branches,
  output logic [CNT_W-1:0]  num_mispredictions
);

  localparam int unsigned EntryW = entry_w(PC_W);

  state_e             state_q;
  logic [ADDR_W:0]    last_q;
  logic [ADDR_W:0]    idx_q;
  logic [ADDR_W-1:0]  rd_addr_q;
  logic               pe_q;
  logic               busy_q;
  logic               done_q;
  logic               misp_q;
  logic [CNT_W-1:0]   nb_q;
  logic [CNT_W-1:0]   nm_q;

  logic               wr_en;
  logic [EntryW-1:0]  wr_data;
  logic [EntryW-1:0]  rd_data;
  logic               cur_outcome;
  logic [PC_W-1:0]    cur_pc;
  logic               miss;

  assign wr_en   = load_en && ((state_q == StIdle) || (state_q == StDone));
  assign wr_data = {load_pc, load_outcome};

  trace_mem #(
    .ADDR_W  (ADDR_W),
    .ENTRY_W (EntryW)
  ) u_trace_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (load_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr_q),
    .rd_data (rd_data)
  );

  assign cur_outcome = rd_data[OutcomeBit];
  assign cur_pc      = rd_data[EntryW-1:PcLsb];
  assign miss        = pe_q && (prediction != cur_outcome);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      last_q    <= '0;
      idx_q     <= '0;
      rd_addr_q <= '0;
      pe_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      misp_q    <= 1'b0;
      nb_q      <= '0;
      nm_q      <= '0;
    end else begin
      misp_q <= miss;
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            last_q    <= trace_len - (ADDR_W + 1)'(1);
            idx_q     <= '0;
            rd_addr_q <= '0;
            nb_q      <= '0;
            nm_q      <= '0;
            if (trace_len == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StPrime;
              done_q  <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
        end
        StPrime: begin
          rd_addr_q <= rd_addr_q + ADDR_W'(1);
          pe_q      <= 1'b1;
          state_q   <= StRun;
        end
        StRun: begin
          // Read address runs one entry ahead of the presented branch; wraps on a full trace.
          rd_addr_q <= rd_addr_q + ADDR_W'(1);
          idx_q     <= idx_q + (ADDR_W + 1)'(1);
          if (nb_q != {CNT_W{1'b1}}) begin
            nb_q <= nb_q + CNT_W'(1);
          end
          if (miss && (nm_q != {CNT_W{1'b1}})) begin
            nm_q <= nm_q + CNT_W'(1);
          end
          if (idx_q == last_q) begin
            state_q <= StDone;
            pe_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign predict_enable     = pe_q;
  assign branch_pc          = pe_q ? cur_pc : '0;
  assign actual_outcome     = pe_q & cur_outcome;
  assign busy               = busy_q;
  assign done               = done_q;
  assign mispredict         = misp_q;
  assign num_branches       = nb_q;
  assign num_mispredictions = nm_q;

endmodule

// File: tb/tb_branch_trace_player.sv
// Directed-plus-random bench for branch_trace_player scored against a trace-array reference model.
module tb_branch_trace_player;

  localparam int unsigned PC_W   = 8;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned DEPTH  = 2**ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [PC_W-1:0]   load_pc;
  logic              load_outcome;
  logic [ADDR_W:0]   trace_len;
  logic              start;
  logic              prediction;

  logic              predict_enable, actual_outcome, busy, done, mispredict;
  logic [PC_W-1:0]   branch_pc;
  logic [CNT_W-1:0]  num_branches, num_mispredictions;

  logic              s_pe, s_act, s_busy, s_done, s_misp;
  logic [PC_W-1:0]   s_bpc;
  logic [3:0]        s_nb, s_nm;

  bit [PC_W-1:0] model_pc  [DEPTH];
  bit            model_out [DEPTH];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_trace_player #(.PC_W(PC_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk (clk), .reset (reset), .load_en (load_en), .load_addr (load_addr),
    .load_pc (load_pc), .load_outcome (load_outcome), .trace_len (trace_len),
    .start (start), .predict_enable (predict_enable), .branch_pc (branch_pc),
    .actual_outcome (actual_outcome), .prediction (prediction), .busy (busy),
    .done (done), .mispredict (mispredict), .num_branches (num_branches),
    .num_mispredictions (num_mispredictions)
  );

  branch_trace_player #(.PC_W(PC_W), .ADDR_W(ADDR_W), .CNT_W(4)) dut_sat (
    .clk (clk), .reset (reset), .load_en (load_en), .load_addr (load_addr),
    .load_pc (load_pc), .load_outcome (load_outcome), .trace_len (trace_len),
    .start (start), .predict_enable (s_pe), .branch_pc (s_bpc),
    .actual_outcome (s_act), .prediction (prediction), .busy (s_busy),
    .done (s_done), .mispredict (s_misp), .num_branches (s_nb),
    .num_mispredictions (s_nm)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int n, input int w);
    int lim;
    lim = (1 << w) - 1;
    return (n > lim) ? lim : n;
  endfunction

  task automatic load_one(input int addr, input int pc, input bit out);
    @(negedge clk);
    load_en      = 1'b1;
    load_addr    = ADDR_W'(addr);
    load_pc      = PC_W'(pc);
    load_outcome = out;
    model_pc[addr]  = PC_W'(pc);
    model_out[addr] = out;
  endtask

  task automatic load_end();
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // mode: 0 predict not-taken, 1 predict taken, 2 random, 3 always wrong
  task automatic run_trace(input int len, input int mode, input int disturb_k, input string tag);
    int  k, exp_nm, pulses, first_pe, cyc;
    bit  seen_done;
    logic p;
    k = 0; exp_nm = 0; pulses = 0; first_pe = -1; cyc = 0; seen_done = 0;
    @(negedge clk);
    trace_len = (ADDR_W + 1)'(len);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_prime_busy"}, busy, 1);
    chk({tag, "_prime_pe"}, predict_enable, 0);
    while (!seen_done && cyc < len + 8) begin
      @(negedge clk);
      load_en = 1'b0;
      start   = 1'b0;
      if (mispredict) pulses++;
      if (done) seen_done = 1;
      if (predict_enable) begin
        if (first_pe < 0) first_pe = cyc;
        if (k < len) begin
          if (branch_pc !== model_pc[k]) chk({tag, "_pc"}, branch_pc, model_pc[k]);
          if (actual_outcome !== model_out[k]) chk({tag, "_out"}, actual_outcome, model_out[k]);
          case (mode)
            0: p = 1'b0;
            1: p = 1'b1;
            2: p = 1'($urandom);
            default: p = ~model_out[k];
          endcase
          if (p != model_out[k]) exp_nm++;
          prediction = p;
          if (k == disturb_k) begin
            load_en      = 1'b1;
            load_addr    = ADDR_W'(20);
            load_pc      = ~model_pc[20];
            load_outcome = ~model_out[20];
            start        = 1'b1;
            trace_len    = (ADDR_W + 1)'(1);
          end
        end
        k++;
      end else begin
        prediction = 1'($urandom);
      end
      cyc++;
    end
    chk({tag, "_done"}, seen_done, 1);
    chk({tag, "_latency"}, first_pe, 0);
    chk({tag, "_presented"}, k, len);
    chk({tag, "_busy_at_done"}, busy, 0);
    chk({tag, "_pe_at_done"}, predict_enable, 0);
    chk({tag, "_num_branches"}, num_branches, sat(len, CNT_W));
    chk({tag, "_num_misp"}, num_mispredictions, sat(exp_nm, CNT_W));
    chk({tag, "_misp_pulses"}, pulses, exp_nm);
  endtask

  initial begin
    int k;
    reset = 1'b1; load_en = 1'b0; load_addr = '0; load_pc = '0; load_outcome = 1'b0;
    trace_len = '0; start = 1'b0; prediction = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_pe", predict_enable, 0);
    chk("rst_pc", branch_pc, 0);
    chk("rst_out", actual_outcome, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_misp", mispredict, 0);
    chk("rst_nb", num_branches, 0);
    chk("rst_nm", num_mispredictions, 0);

    // Three-entry trace, predictor always taken
    load_one(0, 10, 1'b1);
    load_one(1, 20, 1'b0);
    load_one(2, 30, 1'b1);
    load_end();
    run_trace(3, 1, -1, "three");
    chk("three_nb_abs", num_branches, 3);
    chk("three_nm_abs", num_mispredictions, 1);

    // Zero-length replay from DONE
    @(negedge clk);
    trace_len = '0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_nb", num_branches, 0);
    chk("zero_nm", num_mispredictions, 0);
    k = 0;
    repeat (4) begin
      @(negedge clk);
      if (predict_enable) k++;
    end
    chk("zero_pe_never", k, 0);

    // Full-depth trace with alternating outcomes, predictor never taken
    for (int i = 0; i < int'(DEPTH); i++) load_one(i, int'($urandom_range(255)), bit'(i % 2 == 0));
    load_end();
    run_trace(DEPTH, 0, -1, "full");
    chk("full_nm_abs", num_mispredictions, 128);

    // Random trace, random predictions
    for (int i = 0; i < 40; i++) load_one(i, int'($urandom_range(255)), 1'($urandom));
    load_end();
    run_trace(40, 2, -1, "rand");

    // load_en and start during RUN must be ignored
    run_trace(30, 2, 7, "disturb");

    // Reset while entry 5 of 10 is presented
    @(negedge clk);
    trace_len = (ADDR_W + 1)'(10);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    for (int c = 0; c < 20 && k < 6; c++) begin
      @(negedge clk);
      if (predict_enable) k++;
    end
    chk("midrst_reached_k5", k, 6);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_pe", predict_enable, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_nb", num_branches, 0);
    chk("midrst_nm", num_mispredictions, 0);
    run_trace(10, 2, -1, "after_rst");

    // Reload in DONE, then replay new contents
    for (int i = 0; i < 5; i++) load_one(i, int'($urandom_range(255)), 1'($urandom));
    load_end();
    run_trace(5, 2, -1, "reload");

    // Saturation on the 4-bit instance: 20 branches, all mispredicted
    for (int i = 0; i < 20; i++) load_one(i, int'($urandom_range(255)), 1'($urandom));
    load_end();
    run_trace(20, 3, -1, "allmiss");
    chk("sat_nb", s_nb, 15);
    chk("sat_nm", s_nm, 15);
    chk("sat_done", s_done, 1);
    chk("sat_busy", s_busy, 0);
    chk("sat_pe", s_pe, 0);
    chk("sat_bpc", s_bpc, 0);
    chk("sat_act", s_act, 0);
    chk("sat_last_pulse", s_misp, 1);
    @(negedge clk);
    chk("sat_pulse_drop", s_misp, 0);
    chk("sat_nb_hold", s_nb, 15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_trace_player.md
Name: branch_trace_player

Overview:
- Synthesizable stimulus and scoring engine for the gselect predictor interface.
- Holds a branch trace (PC, outcome) in on-chip RAM and replays it into the predictor at one branch per cycle.
- Compares the predictor's combinational `prediction` against each outcome and accumulates branch and misprediction counts.
- Sits opposite gselect on the predict_enable / branch_pc / actual_outcome / prediction interface, for on-FPGA accuracy measurement.

Parameters:
- PC_W, 8, width of branch PC.
- ADDR_W, 8, trace RAM address width; depth = 2**ADDR_W entries.
- CNT_W, 16, width of statistics counters.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- load_en  in  1  write one trace entry this cycle.
- load_addr  in  ADDR_W  trace RAM write address.
- load_pc  in  PC_W  branch PC to store.
- load_outcome  in  1  actual outcome to store (1 = taken).
- trace_len  in  ADDR_W+1  number of entries to replay (0..2**ADDR_W); sampled on start.
- start  in  1  begin replay; single-cycle pulse.
- predict_enable  out  1  branch valid to predictor.
- branch_pc  out  PC_W  PC presented to predictor.
- actual_outcome  out  1  outcome presented to predictor.
- prediction  in  1  predictor's combinational prediction for the presented branch.
- busy  out  1  replay in progress (PRIME or RUN).
- done  out  1  replay complete; stats valid.
- mispredict  out  1  one-cycle pulse, registered, after each misprediction.
- num_branches  out  CNT_W  branches scored.
- num_mispredictions  out  CNT_W  mispredictions scored.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal length and index 0. Trace RAM contents are not reset and survive reset.
- Trace RAM: one write port, one synchronous read port (1-cycle read latency). Entry = {pc, outcome}.
- Loading:
  - Writes are accepted only in IDLE or DONE.
  - load_en in PRIME or RUN is ignored.
- States:
  - IDLE: outputs quiescent. On start: latch trace_len, clear counters, clear done.
    - If trace_len == 0, go to DONE.
    - Otherwise, issue a read of address 0 and go to PRIME.
  - PRIME: one cycle. The read data for entry 0 lands. Issue a read of address 1. Go to RUN.
  - RUN, cycle k (k = 0..len-1):
    - predict_enable = 1; branch_pc and actual_outcome come straight from the registered RAM output (entry k).
    - At the clock edge: num_branches += 1; if prediction != actual_outcome, num_mispredictions += 1 and mispredict = 1 in the next cycle.
    - The read address advances to k+2.
    - When k == len-1, go to DONE at that edge.
    - Throughput is one branch per clock. The predictor updates on the same edges.
  - DONE: predict_enable = 0; done = 1; counters held. A start here behaves as a start from IDLE, including the trace_len == 0 case.
- start in PRIME or RUN is ignored.
- Counters saturate at 2**CNT_W-1 and never wrap.
- When trace_len == 2**ADDR_W, the read address wraps past the last entry; the over-read data is never presented.
- Reset mid-replay: returns to IDLE next cycle. predict_enable drops to 0 and counters clear.
- busy = 1 in PRIME and RUN. done and busy are never both 1.
- load_en to an address while in DONE, followed by start, replays the new data.

Decomposition:
- Package `trace_player_pkg`:
  - State enum {IDLE, PRIME, RUN, DONE}.
  - Entry width constant ENTRY_W = PC_W+1.
  - Field index constants for the pc and outcome slices.
- One sub-module, `trace_mem`: parameterized synchronous-read, single-write RAM (ADDR_W, ENTRY_W), inferable as block RAM.
- FSM, counters and compare live in the top.

Test Plan:
- Load entries {(10,1),(20,0),(30,1)}, trace_len=3, stub predictor prediction=1, pulse start:
  - predict_enable high exactly 3 cycles, starting 2 cycles after start.
  - branch_pc sequence 10, 20, 30.
  - Final num_branches=3, num_mispredictions=1, one mispredict pulse, done=1.
- trace_len=0, start → done=1 one cycle later; predict_enable never asserts; counters 0.
- Full 256-entry trace of alternating outcomes, stub prediction=0 → num_branches=256, num_mispredictions=128, no extra presented entry.
- Assert reset during RUN at k=5 of 10 → next cycle state IDLE, predict_enable=0, counters 0. A later start replays all 10 entries with unchanged RAM contents.
- load_en and start pulsed during RUN → no RAM change, no restart; stats match an undisturbed run.
- CNT_W=4, 20 branches all mispredicted → both counters saturate at 15.
